// File: rtl/inv_shift_rows_pkg.sv
// rtl/inv_shift_rows_pkg.sv - shared AES widths, FSM states and inverse-shift slot function
package inv_shift_rows_pkg;

    localparam int BYTE_W      = 8;
    localparam int STATE_BYTES = 16;
    localparam int STATE_W     = BYTE_W * STATE_BYTES;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    // Byte k = 4c+r lands in column (c+r) mod 4 of the same row; the 2-bit add wraps for free.
    function automatic logic [3:0] inv_shift_slot(input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] c_new;
        r     = k[1:0];
        c     = k[3:2];
        c_new = c + r;
        return {c_new, r};
    endfunction

endpackage

// File: rtl/inv_shift_rows_map.sv
// rtl/inv_shift_rows_map.sv - combinational byte index to load-buffer slot index
module inv_shift_rows_map
    import inv_shift_rows_pkg::*;
(
    input  logic [3:0] byte_idx,
    output logic [3:0] slot_idx
);

    assign slot_idx = inv_shift_slot(byte_idx);

endmodule

// File: rtl/inv_shift_rows.sv
// rtl/inv_shift_rows.sv - byte-serial AES InvShiftRows with double-buffered 128-bit output
module inv_shift_rows
    import inv_shift_rows_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_byte,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [0:STATE_W-1]   out_data,
    input  logic                 out_ready,
    output logic                 done
);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [0:STATE_W-1]   buf_q, buf_d;
    logic [0:STATE_W-1]   out_q, out_d;
    logic                 out_valid_q, out_valid_d;

    logic [3:0]           slot;
    logic [0:STATE_W-1]   buf_wr;
    logic                 accept;
    logic                 take;

    inv_shift_rows_map u_map (
        .byte_idx (cnt_q),
        .slot_idx (slot)
    );

    assign in_ready  = rst & (state_q == ST_LOAD);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid_q & out_ready;
    assign done      = rst & take;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        buf_wr      = buf_q;
        buf_wr[{slot, 3'b000} +: BYTE_W] = in_byte;

        if (take) begin
            out_valid_d = 1'b0;
        end

        if (abort) begin
            cnt_d   = 4'd0;
            buf_d   = '0;
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        cnt_d = cnt_q + 4'd1;
                        buf_d = buf_wr;
                        if (cnt_q == 4'hf) begin
                            // The final byte goes straight through to the output when it is free.
                            if (!out_valid_q || take) begin
                                out_d       = buf_wr;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d = ST_FULL;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        out_d       = buf_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_LOAD;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= 4'd0;
            buf_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows.sv
// tb/tb_inv_shift_rows.sv - scoreboard bench for inv_shift_rows
module tb_inv_shift_rows;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_byte = 8'h00;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [0:127] out_data;
    logic         done;

    localparam logic [127:0] REF_SEQ = 128'h000d0a0704010e0b0805020f0c090603;

    int           checks = 0;
    int           failures = 0;
    logic [127:0] sb[$];
    logic [127:0] mstate;
    int           nbytes = 0;
    int           done_cnt = 0;
    logic         last_acc;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic         rand_ready = 1'b0;
    logic         rt_mode = 1'b0;
    logic [127:0] rt_state;

    inv_shift_rows dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inverse shift straight from the transform: out(r,c) = in(r,(c-r) mod 4).
    function automatic logic [127:0] inv_model(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c - r + 4) % 4) + r;
                o[127 - 8*(4*c+r) -: 8] = s[127 - 8*src -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c + r) % 4) + r;
                o[127 - 8*(4*c+r) -: 8] = s[127 - 8*src -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] rand_state();
        logic [127:0] s;
        for (int i = 0; i < 4; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // One clock: observe and score at the falling edge, then step past the rising edge.
    task automatic tick();
        logic acc;
        logic tk;
        @(negedge clk);
        acc = in_valid & in_ready;
        tk  = out_valid & out_ready;
        if (rst) begin
            if (prev_stall) begin
                chk("stall_valid", {127'd0, out_valid}, 128'd1);
                chk("stall_data", out_data, prev_data);
            end
            chk("done_pulse", {127'd0, done}, {127'd0, tk});
            if (done) done_cnt++;
            if (tk) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_output observed=%h expected=none", out_data);
                end else begin
                    chk("out_data", out_data, sb.pop_front());
                end
            end
        end else begin
            chk("done_in_reset", {127'd0, done}, 128'd0);
            chk("in_ready_in_reset", {127'd0, in_ready}, 128'd0);
        end
        if (!rst) begin
            sb.delete();
            nbytes = 0;
        end else if (abort) begin
            nbytes = 0;
        end else if (acc) begin
            mstate[127 - 8*nbytes -: 8] = in_byte;
            if (nbytes == 15) sb.push_back(rt_mode ? rt_state : inv_model(mstate));
            nbytes = (nbytes + 1) % 16;
        end
        last_acc   = acc;
        prev_stall = rst & out_valid & ~out_ready;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=no_accept expected=accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_state(input logic [127:0] s);
        for (int k = 0; k < 16; k++) send_byte(s[127 - 8*k -: 8]);
    endtask

    task automatic send_seq();
        for (int k = 0; k < 16; k++) send_byte(8'(k));
    endtask

    initial begin
        logic [127:0] s1;
        logic [127:0] s2;
        int d0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

        // Bytes 00..0f with a free output
        out_ready = 1'b1;
        d0 = done_cnt;
        send_seq();
        chk("seq_latency_valid", {127'd0, out_valid}, 128'd1);
        chk("seq_value", out_data, REF_SEQ);
        tick();
        tick();
        chk("seq_done_once", 128'(done_cnt - d0), 128'd1);
        chk("seq_valid_fall", {127'd0, out_valid}, 128'd0);

        // Backpressure: two states with the consumer stalled
        out_ready = 1'b0;
        s1 = rand_state();
        s2 = rand_state();
        send_state(s1);
        send_state(s2);
        chk("full_in_ready", {127'd0, in_ready}, 128'd0);
        chk("full_hold_data", out_data, inv_model(s1));
        out_ready = 1'b1;
        tick();
        chk("full_second_valid", {127'd0, out_valid}, 128'd1);
        chk("full_second_data", out_data, inv_model(s2));
        chk("full_in_ready_back", {127'd0, in_ready}, 128'd1);
        tick();

        // Abort after 7 bytes, then a clean sequence
        for (int k = 0; k < 7; k++) send_byte(8'($urandom));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        send_seq();
        chk("abort_seq_value", out_data, REF_SEQ);
        tick();

        // Abort coinciding with byte 15
        for (int k = 0; k < 15; k++) send_byte(8'($urandom));
        in_valid = 1'b1;
        in_byte  = 8'hee;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        chk("abort15_no_valid", {127'd0, out_valid}, 128'd0);
        chk("abort15_no_pending", 128'(sb.size()), 128'd0);
        send_seq();
        chk("abort15_seq_value", out_data, REF_SEQ);
        tick();

        // Reset with a held output and a partial load
        out_ready = 1'b0;
        send_state(rand_state());
        for (int k = 0; k < 5; k++) send_byte(8'($urandom));
        rst = 1'b0;
        tick();
        chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        s1 = rand_state();
        send_state(s1);
        chk("midrst_next_state", out_data, inv_model(s1));
        tick();

        // Round trip through the forward transform
        rt_mode = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            rt_state = rand_state();
            send_state(fwd_model(rt_state));
        end
        tick();
        tick();
        rt_mode = 1'b0;

        // Random input gaps and consumer stalls
        rand_ready = 1'b1;
        for (int v = 0; v < 200; v++) begin
            s1 = rand_state();
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 1) == 1) tick();
                send_byte(s1[127 - 8*k -: 8]);
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (6) tick();
        chk("drain_empty", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
